// File: rtl/branch_writeback_arbiter.sv
// Branch writeback arbiter: round-robin pick of a ready branch RS entry into a
// single result slot, which is held and offered to the CDB until it is granted.
module branch_writeback_arbiter #(
  parameter int RS_SIZE   = 4,
  parameter int ROB_IDX_W = 4,
  parameter int RES_W     = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [RS_SIZE-1:0]            rs_ready_i,
  input  logic [RS_SIZE*32-1:0]         rs_data_i,
  input  logic [RS_SIZE*ROB_IDX_W-1:0]  rs_reorder_i,
  input  logic [RS_SIZE*RES_W-1:0]      rs_resolved_i,
  output logic [RS_SIZE-1:0]            rs_ack_o,
  output logic                          cdb_req_o,
  input  logic                          cdb_grant_i,
  output logic [31:0]                   cdb_value_o,
  output logic [ROB_IDX_W-1:0]          cdb_reorder_o,
  output logic                          resolved_valid_o,
  output logic [RES_W-1:0]              resolved_o
);

  localparam int PTR_W = $clog2(RS_SIZE);

  logic                 slot_valid;
  logic [31:0]          slot_value;
  logic [ROB_IDX_W-1:0] slot_reorder;
  logic [RES_W-1:0]     slot_resolved;
  logic [PTR_W-1:0]     rr_ptr;

  logic                 accept;
  logic                 can_load;
  logic                 capture;
  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     cand;

  assign accept   = slot_valid & cdb_grant_i;
  assign can_load = ~slot_valid | accept;

  // Scan from the farthest offset back to rr_ptr so the nearest ready entry wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      cand = rr_ptr + PTR_W'(i);
      if (rs_ready_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign capture = pick_valid & can_load & ~flush & ~rst;

  always_comb begin
    rs_ack_o = '0;
    for (int k = 0; k < RS_SIZE; k++) begin
      rs_ack_o[k] = capture && (pick_idx == PTR_W'(k));
    end
  end

  // A flush or reset in the grant cycle drops the slot without handing it off.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slot_valid    <= 1'b0;
      slot_value    <= '0;
      slot_reorder  <= '0;
      slot_resolved <= '0;
      rr_ptr        <= '0;
    end else if (capture) begin
      slot_valid    <= 1'b1;
      slot_value    <= rs_data_i[32*pick_idx +: 32];
      slot_reorder  <= rs_reorder_i[ROB_IDX_W*pick_idx +: ROB_IDX_W];
      slot_resolved <= rs_resolved_i[RES_W*pick_idx +: RES_W];
      rr_ptr        <= pick_idx + 1'b1;
    end else if (accept) begin
      slot_valid    <= 1'b0;
    end
  end

  assign cdb_req_o        = slot_valid;
  assign cdb_value_o      = slot_value;
  assign cdb_reorder_o    = slot_reorder;
  assign resolved_o       = slot_resolved;
  assign resolved_valid_o = accept & ~flush & ~rst;

endmodule

// File: tb/tb_branch_writeback_arbiter.sv
// Self-checking bench for branch_writeback_arbiter: directed scenarios followed by
// random traffic, compared against a queue-free behavioural model of the slot.
module tb_branch_writeback_arbiter;

  localparam int N  = 4;
  localparam int RW = 4;
  localparam int PW = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [N-1:0]      rs_ready_i;
  logic [N*32-1:0]   rs_data_i;
  logic [N*RW-1:0]   rs_reorder_i;
  logic [N*PW-1:0]   rs_resolved_i;
  logic [N-1:0]      rs_ack_o;
  logic              cdb_req_o;
  logic              cdb_grant_i;
  logic [31:0]       cdb_value_o;
  logic [RW-1:0]     cdb_reorder_o;
  logic              resolved_valid_o;
  logic [PW-1:0]     resolved_o;

  always #5 clk = ~clk;

  branch_writeback_arbiter #(.RS_SIZE(N), .ROB_IDX_W(RW), .RES_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rs_ready_i(rs_ready_i), .rs_data_i(rs_data_i),
    .rs_reorder_i(rs_reorder_i), .rs_resolved_i(rs_resolved_i),
    .rs_ack_o(rs_ack_o), .cdb_req_o(cdb_req_o), .cdb_grant_i(cdb_grant_i),
    .cdb_value_o(cdb_value_o), .cdb_reorder_o(cdb_reorder_o),
    .resolved_valid_o(resolved_valid_o), .resolved_o(resolved_o)
  );

  // Reservation-station view kept by the bench
  logic [31:0]   data [N];
  logic [RW-1:0] reo  [N];
  logic [PW-1:0] res  [N];
  logic [N-1:0]  rdy;
  logic          grant_q, flush_q, rst_q;

  // Behavioural model of the slot
  bit            m_valid, m_clean;
  logic [31:0]   m_value;
  logic [RW-1:0] m_reorder;
  logic [PW-1:0] m_resolved;
  int            m_ptr;
  int            exp_k;
  bit            exp_ack, exp_rv;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomizeEntries();
    logic [63:0] r64;
    for (int i = 0; i < N; i++) begin
      data[i] = $urandom();
      reo[i]  = RW'($urandom_range(0, (1 << RW) - 1));
      r64     = {$urandom(), $urandom()};
      res[i]  = r64[PW-1:0];
    end
  endtask

  task automatic applyStimulus(input logic g, input logic f, input logic r);
    grant_q = g; flush_q = f; rst_q = r;
    cdb_grant_i = g; flush = f; rst = r;
    rs_ready_i = rdy;
    for (int i = 0; i < N; i++) begin
      rs_data_i[i*32 +: 32]     = data[i];
      rs_reorder_i[i*RW +: RW]  = reo[i];
      rs_resolved_i[i*PW +: PW] = res[i];
    end
  endtask

  task automatic modelReset();
    m_valid = 0; m_clean = 1; m_ptr = 0;
    m_value = '0; m_reorder = '0; m_resolved = '0;
  endtask

  task automatic modelEval();
    exp_k = -1;
    for (int i = 0; i < N; i++)
      if (exp_k < 0 && rdy[(m_ptr + i) % N]) exp_k = (m_ptr + i) % N;
    exp_ack = (exp_k >= 0) && (!m_valid || grant_q) && !flush_q && !rst_q;
    exp_rv  = m_valid && grant_q && !flush_q && !rst_q;
  endtask

  task automatic checkOutput(input string tag);
    modelEval();
    check({tag, ".ack"}, 64'(rs_ack_o), exp_ack ? (64'd1 << exp_k) : 64'd0);
    check({tag, ".req"}, 64'(cdb_req_o), 64'(m_valid));
    check({tag, ".rvalid"}, 64'(resolved_valid_o), 64'(exp_rv));
    if (m_valid || m_clean) begin
      check({tag, ".value"}, 64'(cdb_value_o), 64'(m_value));
      check({tag, ".reorder"}, 64'(cdb_reorder_o), 64'(m_reorder));
      check({tag, ".resolved"}, 64'(resolved_o), 64'(m_resolved));
    end
  endtask

  task automatic modelUpdate();
    if (rst_q || flush_q) begin
      modelReset();
    end else if (exp_ack) begin
      m_valid = 1; m_clean = 0;
      m_value = data[exp_k]; m_reorder = reo[exp_k]; m_resolved = res[exp_k];
      m_ptr = (exp_k + 1) % N;
      rdy[exp_k] = 1'b0;
    end else if (exp_rv) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive after the edge, check at the falling edge, advance model at the rising edge.
  task automatic step(input string tag, input logic g, input logic f, input logic r);
    applyStimulus(g, f, r);
    #4;
    checkOutput(tag);
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  initial begin
    randomizeEntries();
    rdy = '0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    modelReset();
    #1;

    for (int c = 0; c < 10; c++) step("idle", 1'b0, 1'b0, 1'b0);

    data[2] = 32'hBFC00010; reo[2] = 4'd5;
    rdy = 4'b0100;
    step("single.ack", 1'b1, 1'b0, 1'b0);
    check("single.ptr", 64'(m_ptr), 64'd3);
    step("single.req", 1'b1, 1'b0, 1'b0);
    check("single.value_const", 64'(cdb_value_o), 64'hBFC00010);

    step("rr.reset", 1'b1, 1'b0, 1'b1);
    rdy = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      randomizeEntries();
      step("rr", 1'b1, 1'b0, 1'b0);
      if (rdy == '0) rdy = 4'b1111;
    end

    step("bp.reset", 1'b1, 1'b0, 1'b1);
    reo[0] = 4'd2; rdy = 4'b0001;
    step("bp.load", 1'b0, 1'b0, 1'b0);
    rdy = 4'b1000;
    for (int c = 0; c < 3; c++) step("bp.hold", 1'b0, 1'b0, 1'b0);
    check("bp.reorder_const", 64'(cdb_reorder_o), 64'd2);
    step("bp.grant", 1'b1, 1'b0, 1'b0);

    step("wrap.reset", 1'b1, 1'b0, 1'b1);
    rdy = 4'b0100;
    step("wrap.prime", 1'b1, 1'b0, 1'b0);
    rdy = 4'b1001;
    step("wrap.e3", 1'b1, 1'b0, 1'b0);
    step("wrap.e0", 1'b1, 1'b0, 1'b0);
    check("wrap.ptr", 64'(m_ptr), 64'd1);

    rdy = 4'b0001;
    step("flush.load", 1'b0, 1'b0, 1'b0);
    rdy = 4'b0010;
    step("flush.grant", 1'b1, 1'b1, 1'b0);
    rdy = 4'b1010;
    step("flush.after", 1'b0, 1'b0, 1'b0);

    rdy = 4'b0100;
    step("rstbp.load", 1'b0, 1'b0, 1'b0);
    step("rstbp.hold", 1'b0, 1'b0, 1'b0);
    step("rstbp.rst", 1'b1, 1'b0, 1'b1);
    step("rstbp.after", 1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 400; c++) begin
      randomizeEntries();
      rdy = rdy | N'($urandom_range(0, (1 << N) - 1));
      step("rand", $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
